// File: rtl/uart_scrambler_txrx.sv
// uart_scrambler_txrx: full-duplex UART with LFSR keystream scrambling.
//
// TX XORs each accepted word with the TX LFSR key and serialises it
// (start, data LSB first, optional even parity, stop). RX synchronises the
// line, rejects short start glitches, deserialises, and XORs with the RX
// LFSR key. Each path has its own LFSR, which steps once per frame.
//
// Ports:
//   M_CLOCK        clock
//   M_RESET        asynchronous active-high reset
//   tx_data        plaintext word to send
//   tx_valid       tx_data offered
//   tx_ready       transmitter idle, accepts tx_data this cycle
//   tx_out         serial line out, idle high
//   rx_in          asynchronous serial line in
//   rx_data        descrambled received word (held until next rx_valid)
//   rx_valid       one-cycle strobe for rx_data / error flags
//   rx_parity_err  even-parity mismatch (only when PARITY_EN)
//   rx_frame_err   stop bit sampled as 0
//   lfsr_resync    reload LFSR_SEED into both LFSRs
module uart_scrambler_txrx #(
  parameter int unsigned BAUD_DIV    = 5208,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PARITY_EN   = 0,
  parameter int unsigned SCRAMBLE_EN = 1,
  parameter logic [7:0]  LFSR_SEED   = 8'hFF
) (
  input  logic              M_CLOCK,
  input  logic              M_RESET,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  input  logic              rx_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  input  logic              lfsr_resync
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6], l[5], l[4], l[3] ^ l[7], l[2] ^ l[7], l[1], l[0], l[7]};
  endfunction

  function automatic logic [DATA_W-1:0] key_of(input logic [7:0] l);
    return (SCRAMBLE_EN != 0) ? l[DATA_W-1:0] : '0;
  endfunction

  // ---------------- TX ----------------
  state_t            tx_state_q, tx_state_d;
  logic [15:0]       tx_baud_q, tx_baud_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [7:0]        tx_lfsr_q, tx_lfsr_d, tx_lfsr_cur;
  logic              tx_out_q, tx_out_d;

  always_comb begin
    tx_lfsr_cur = lfsr_resync ? LFSR_SEED : tx_lfsr_q;
    tx_state_d  = tx_state_q;
    tx_baud_d   = tx_baud_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_lfsr_d   = tx_lfsr_cur;
    tx_out_d    = 1'b1;
    tx_ready    = (tx_state_q == IDLE);

    if (tx_state_q == IDLE) begin
      if (tx_valid) begin
        tx_shift_d = tx_data ^ key_of(tx_lfsr_cur);
        tx_lfsr_d  = lfsr_next(tx_lfsr_cur);
        tx_state_d = START;
        tx_baud_d  = '0;
      end
    end else if (tx_baud_q == BAUD_LAST) begin
      tx_baud_d = '0;
      case (tx_state_q)
        START: begin
          tx_state_d = DATA;
          tx_bit_d   = '0;
        end
        DATA: begin
          if (tx_bit_q == BIT_LAST) tx_state_d = (PARITY_EN != 0) ? PARITY : STOP;
          else                      tx_bit_d   = tx_bit_q + 3'd1;
        end
        PARITY:  tx_state_d = STOP;
        default: tx_state_d = IDLE;
      endcase
    end else begin
      tx_baud_d = tx_baud_q + 16'd1;
    end

    // Line level is registered from the next state so tx_out is glitch-free.
    case (tx_state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = tx_shift_d[tx_bit_d];
      PARITY:  tx_out_d = ^tx_shift_d;
      default: tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge M_CLOCK or posedge M_RESET) begin
    if (M_RESET) begin
      tx_state_q <= IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_lfsr_q  <= LFSR_SEED;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_lfsr_q  <= tx_lfsr_d;
      tx_out_q   <= tx_out_d;
    end
  end

  assign tx_out = tx_out_q;

  // ---------------- RX ----------------
  logic              rx_sync1_q, rx_sync2_q;
  state_t            rx_state_q, rx_state_d;
  logic [15:0]       rx_baud_q, rx_baud_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_par_q, rx_par_d;
  logic [7:0]        rx_lfsr_q, rx_lfsr_d, rx_lfsr_cur;
  logic              rx_wait_high_q, rx_wait_high_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_perr_q, rx_perr_d;
  logic              rx_ferr_q, rx_ferr_d;

  always_comb begin
    rx_lfsr_cur    = lfsr_resync ? LFSR_SEED : rx_lfsr_q;
    rx_state_d     = rx_state_q;
    rx_baud_d      = rx_baud_q;
    rx_bit_d       = rx_bit_q;
    rx_shift_d     = rx_shift_q;
    rx_par_d       = rx_par_q;
    rx_lfsr_d      = rx_lfsr_cur;
    rx_wait_high_d = rx_wait_high_q;
    rx_valid_d     = 1'b0;
    rx_data_d      = rx_data_q;
    rx_perr_d      = rx_perr_q;
    rx_ferr_d      = rx_ferr_q;

    case (rx_state_q)
      IDLE: begin
        // After a framing error the line must go high before a new start.
        if (rx_wait_high_q) begin
          if (rx_sync2_q) rx_wait_high_d = 1'b0;
        end else if (!rx_sync2_q) begin
          rx_state_d = START;
          rx_baud_d  = '0;
        end
      end
      START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync2_q ? IDLE : DATA;
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      default: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d = '0;
          case (rx_state_q)
            DATA: begin
              rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_W-1:1]};
              if (rx_bit_q == BIT_LAST) rx_state_d = (PARITY_EN != 0) ? PARITY : STOP;
              else                      rx_bit_d   = rx_bit_q + 3'd1;
            end
            PARITY: begin
              rx_par_d   = rx_sync2_q;
              rx_state_d = STOP;
            end
            default: begin
              rx_valid_d     = 1'b1;
              rx_data_d      = rx_shift_q ^ key_of(rx_lfsr_cur);
              rx_perr_d      = (PARITY_EN != 0) && (rx_par_q != ^rx_shift_q);
              rx_ferr_d      = !rx_sync2_q;
              rx_wait_high_d = !rx_sync2_q;
              rx_lfsr_d      = lfsr_next(rx_lfsr_cur);
              rx_state_d     = IDLE;
            end
          endcase
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge M_CLOCK or posedge M_RESET) begin
    if (M_RESET) begin
      rx_sync1_q     <= 1'b1;
      rx_sync2_q     <= 1'b1;
      rx_state_q     <= IDLE;
      rx_baud_q      <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_par_q       <= 1'b0;
      rx_lfsr_q      <= LFSR_SEED;
      rx_wait_high_q <= 1'b0;
      rx_valid_q     <= 1'b0;
      rx_data_q      <= '0;
      rx_perr_q      <= 1'b0;
      rx_ferr_q      <= 1'b0;
    end else begin
      rx_sync1_q     <= rx_in;
      rx_sync2_q     <= rx_sync1_q;
      rx_state_q     <= rx_state_d;
      rx_baud_q      <= rx_baud_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_par_q       <= rx_par_d;
      rx_lfsr_q      <= rx_lfsr_d;
      rx_wait_high_q <= rx_wait_high_d;
      rx_valid_q     <= rx_valid_d;
      rx_data_q      <= rx_data_d;
      rx_perr_q      <= rx_perr_d;
      rx_ferr_q      <= rx_ferr_d;
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_scrambler_txrx.sv
// Bench for uart_scrambler_txrx: instance A (no parity) runs loopback or a
// bench-driven line; instance P (even parity) runs loopback with an optional
// inverted parity bit. Expected words go into per-instance queues at send
// time and are popped on each rx_valid.
module tb_uart_scrambler_txrx;

  localparam int unsigned BAUD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0] tx_data_a, rx_data_a;
  logic tx_valid_a, tx_ready_a, tx_out_a, rx_in_a, rx_valid_a, rx_perr_a, rx_ferr_a, resync_a;
  logic loop_a, line_a;
  assign rx_in_a = loop_a ? tx_out_a : line_a;

  logic [7:0] tx_data_p, rx_data_p;
  logic tx_valid_p, tx_ready_p, tx_out_p, rx_in_p, rx_valid_p, rx_perr_p, rx_ferr_p, resync_p;
  logic inv_p;
  assign rx_in_p = tx_out_p ^ inv_p;

  uart_scrambler_txrx #(.BAUD_DIV(4), .DATA_W(8), .PARITY_EN(0), .SCRAMBLE_EN(1), .LFSR_SEED(8'hFF)) dut_a (
    .M_CLOCK(clk), .M_RESET(rst),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_out(tx_out_a),
    .rx_in(rx_in_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a), .lfsr_resync(resync_a)
  );

  uart_scrambler_txrx #(.BAUD_DIV(4), .DATA_W(8), .PARITY_EN(1), .SCRAMBLE_EN(1), .LFSR_SEED(8'hFF)) dut_p (
    .M_CLOCK(clk), .M_RESET(rst),
    .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p), .tx_out(tx_out_p),
    .rx_in(rx_in_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .rx_parity_err(rx_perr_p), .rx_frame_err(rx_ferr_p), .lfsr_resync(resync_p)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_p[$];
  exp_t ea, ep;
  int errors = 0;
  int checks = 0;
  logic [7:0] ktx_a, krx_a, ktx_p, krx_p;
  logic [9:0] cap;
  logic [7:0] last_a, rd;

  function automatic logic [7:0] nxt(input logic [7:0] l);
    return {l[6], l[5], l[4], l[3] ^ l[7], l[2] ^ l[7], l[1], l[0], l[7]};
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loopback frame on A; returns at the negedge where tx_ready is back.
  task automatic send_a(input logic [7:0] d);
    logic [7:0] w;
    int n;
    w = d ^ ktx_a;
    ktx_a = nxt(ktx_a);
    krx_a = nxt(krx_a);
    q_a.push_back(mk(d, 1'b0, 1'b0));
    last_a = d;
    tx_data_a = d;
    tx_valid_a = 1'b1;
    n = 0;
    while (!tx_ready_a && n < 200) begin @(negedge clk); n++; end
    check("a_ready_wait", tx_ready_a, 1);
    @(posedge clk);
    #1 tx_valid_a = 1'b0;
    n = 0;
    cap = '0;
    @(negedge clk);
    while (!tx_ready_a && n < 200) begin
      if (n % BAUD == 2 && n < 10 * BAUD) cap[n / BAUD] = tx_out_a;
      n++;
      @(negedge clk);
    end
    check("a_ready_low", n, 40);
    check("a_wire", cap, {1'b1, w, 1'b0});
  endtask

  task automatic send_p(input logic [7:0] d, input logic flip);
    int n;
    ktx_p = nxt(ktx_p);
    krx_p = nxt(krx_p);
    q_p.push_back(mk(d, flip, 1'b0));
    tx_data_p = d;
    tx_valid_p = 1'b1;
    n = 0;
    while (!tx_ready_p && n < 200) begin @(negedge clk); n++; end
    check("p_ready_wait", tx_ready_p, 1);
    @(posedge clk);
    #1 tx_valid_p = 1'b0;
    n = 0;
    @(negedge clk);
    while (!tx_ready_p && n < 200) begin
      inv_p = flip && (n >= 36) && (n < 40);
      n++;
      @(negedge clk);
    end
    inv_p = 1'b0;
    check("p_ready_low", n, 44);
  endtask

  // Bench-driven frame on A's line, scrambled with the modelled RX key.
  task automatic drive_frame_a(input logic [7:0] d, input logic stop, input int hold0);
    logic [7:0] w;
    w = d ^ krx_a;
    krx_a = nxt(krx_a);
    q_a.push_back(mk(d, 1'b0, !stop));
    last_a = d;
    line_a = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line_a = w[i];
      repeat (BAUD) @(negedge clk);
    end
    line_a = stop;
    repeat (BAUD) @(negedge clk);
    repeat (hold0) @(negedge clk);
    line_a = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() + q_p.size()) != 0 && n < 500) begin @(negedge clk); n++; end
    check("drain", q_a.size() + q_p.size(), 0);
  endtask

  task automatic pulse_resync();
    resync_a = 1'b1;
    @(negedge clk);
    resync_a = 1'b0;
    ktx_a = 8'hFF;
    krx_a = 8'hFF;
  endtask

  initial begin
    rst = 1'b1;
    tx_data_a = '0; tx_valid_a = 1'b0; resync_a = 1'b0; loop_a = 1'b1; line_a = 1'b1;
    tx_data_p = '0; tx_valid_p = 1'b0; resync_p = 1'b0; inv_p = 1'b0;
    ktx_a = 8'hFF; krx_a = 8'hFF; ktx_p = 8'hFF; krx_p = 8'hFF;
    last_a = '0;

    fork
      forever begin
        @(negedge clk);
        if (rx_valid_a) begin
          if (q_a.size() == 0) check("a_unexpected_rx_valid", rx_valid_a, 0);
          else begin
            ea = q_a.pop_front();
            check("a_rx_data", rx_data_a, ea.d);
            check("a_parity_err", rx_perr_a, ea.pe);
            check("a_frame_err", rx_ferr_a, ea.fe);
          end
        end
      end
      forever begin
        @(negedge clk);
        if (rx_valid_p) begin
          if (q_p.size() == 0) check("p_unexpected_rx_valid", rx_valid_p, 0);
          else begin
            ep = q_p.pop_front();
            check("p_rx_data", rx_data_p, ep.d);
            check("p_parity_err", rx_perr_p, ep.pe);
            check("p_frame_err", rx_ferr_p, ep.fe);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_out", tx_out_a, 1);
    check("rst_tx_ready", tx_ready_a, 1);
    check("rst_rx_valid", rx_valid_a, 0);
    check("rst_rx_data", rx_data_a, 0);
    check("rst_perr", rx_perr_a, 0);
    check("rst_ferr", rx_ferr_a, 0);
    check("rst_p_tx_ready", tx_ready_p, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback: 3C -> wire C3, then 00 -> wire E7, then three more
    send_a(8'h3C);
    check("a_wire_c3", cap, 10'b11_1000_0110);
    send_a(8'h00);
    check("a_wire_e7", cap, {1'b1, 8'hE7, 1'b0});
    send_a(8'hA5);
    send_a(8'h5A);
    rd = 8'($urandom_range(0, 255));
    send_a(rd);
    drain();
    repeat (5) @(negedge clk);
    check("a_rx_data_hold", rx_data_a, last_a);

    // Resync after five frames: next key is FF
    pulse_resync();
    send_a(8'h12);
    check("a_wire_resync", cap, {1'b1, 8'hED, 1'b0});
    drain();

    // One-cycle glitch, then a real frame shortly after
    loop_a = 1'b0;
    repeat (4) @(negedge clk);
    line_a = 1'b0;
    @(negedge clk);
    line_a = 1'b1;
    repeat (3) @(negedge clk);
    drive_frame_a(8'h96, 1'b1, 0);
    drain();

    // Stop bit held low, then line back high and a good frame
    drive_frame_a(8'h3C, 1'b0, 24);
    drain();
    check("a_ferr_hold", rx_ferr_a, 1);
    drive_frame_a(8'hC5, 1'b1, 0);
    drain();
    check("a_ferr_cleared", rx_ferr_a, 0);

    // Re-align both LFSRs and go back to loopback
    loop_a = 1'b1;
    pulse_resync();
    send_a(8'h77);
    drain();

    // Reset mid-DATA with an all-zero wire word
    tx_data_a = ktx_a;
    tx_valid_a = 1'b1;
    @(posedge clk);
    #1 tx_valid_a = 1'b0;
    repeat (14) @(negedge clk);
    check("a_mid_data_low", tx_out_a, 0);
    #2 rst = 1'b1;
    #1;
    check("a_async_tx_out", tx_out_a, 1);
    check("a_async_tx_ready", tx_ready_a, 1);
    check("a_async_rx_valid", rx_valid_a, 0);
    @(negedge clk);
    rst = 1'b0;
    ktx_a = 8'hFF; krx_a = 8'hFF; ktx_p = 8'hFF; krx_p = 8'hFF;
    repeat (60) @(negedge clk);
    send_a(8'h3C);
    check("a_wire_after_reset", cap, 10'b11_1000_0110);
    drain();

    // Parity instance: clean, inverted parity bit, then clean again
    send_p(8'h3C, 1'b0);
    send_p(8'h81, 1'b1);
    send_p(8'h42, 1'b0);
    send_p(8'hE0, 1'b0);
    drain();

    check("a_queue_empty", q_a.size(), 0);
    check("p_queue_empty", q_p.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
